// File: rtl/h265enc_axi_wr_upsizer.sv
// h265enc_axi_wr_upsizer
//   AXI4 write-path up-converter: packs 128-bit INCR write bursts from the
//   H.265 encoder core into 1024-bit beats for the SNAP host write channels,
//   and returns the host write response to the encoder. One burst in flight.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_axi_aw*         : encoder write address (awaddr/len/size/burst/cache/prot)
//   s_axi_w*          : encoder narrow write data (wdata/wstrb/wlast)
//   s_axi_b*          : response to the encoder
//   m_axi_aw*         : host write address (aligned, wide burst length)
//   m_axi_w*          : host wide write data with packed lane strobes
//   m_axi_b*          : host write response
//   wr_err            : sticky protocol-error flag
//
// Build option
//   H265ENC_WR_ERR_CHK_EN : enables AW size/burst and wlast/beat-count checks,
//   drives wr_err and forces SLVERR on a faulty burst. Undefined: wr_err = 0
//   and the host response passes through unchanged.

module h265enc_axi_wr_upsizer #(
  parameter int S_DWIDTH = 128,
  parameter int M_DWIDTH = 1024,
  parameter int AWIDTH   = 64,
  parameter int RATIO    = M_DWIDTH / S_DWIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AWIDTH-1:0]       s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [S_DWIDTH-1:0]     s_axi_wdata,
  input  logic [S_DWIDTH/8-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [AWIDTH-1:0]       m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [M_DWIDTH-1:0]     m_axi_wdata,
  output logic [M_DWIDTH/8-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    wr_err
);

  localparam int S_BYTES = S_DWIDTH / 8;
  localparam int M_BYTES = M_DWIDTH / 8;
  localparam int LANE_W  = $clog2(RATIO);
  localparam int S_OFF_W = $clog2(S_BYTES);
  localparam int M_OFF_W = $clog2(M_BYTES);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state;
  logic [LANE_W-1:0] ptr;        // next lane to fill in the wide buffer
  logic [7:0]        wcnt;       // wide beats already sent
  logic              seen_last;  // narrow wlast sits in the pending wide beat
  logic [LANE_W-1:0] lane0;

  // Starting lane of the burst inside the first wide beat.
  assign lane0 = s_axi_awaddr[M_OFF_W-1:S_OFF_W];

  assign m_axi_awsize  = 3'(M_OFF_W);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wlast   = m_axi_wvalid && (wcnt == m_axi_awlen);

`ifdef H265ENC_WR_ERR_CHK_EN
  logic       err_burst;
  logic [7:0] awlen_q;
  logic [7:0] ncnt;
  logic       unused_ok;
  assign unused_ok = &{1'b0, s_axi_awaddr[S_OFF_W-1:0]};
`else
  logic       unused_ok;
  assign unused_ok = &{1'b0, s_axi_awaddr[S_OFF_W-1:0], s_axi_awsize, s_axi_awburst};
  assign wr_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      wcnt          <= '0;
      seen_last     <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awcache <= '0;
      m_axi_awprot  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
`ifdef H265ENC_WR_ERR_CHK_EN
      err_burst     <= 1'b0;
      awlen_q       <= '0;
      ncnt          <= '0;
      wr_err        <= 1'b0;
`endif
    end else begin
      case (state)
        // Accept one burst, latch the wide address and length.
        IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            m_axi_awaddr  <= {s_axi_awaddr[AWIDTH-1:M_OFF_W], {M_OFF_W{1'b0}}};
            // 9-bit sum so a burst reaching lane RATIO-1 of beat 255 cannot wrap early.
            m_axi_awlen   <= 8'((9'(lane0) + 9'(s_axi_awlen)) >> LANE_W);
            m_axi_awcache <= s_axi_awcache;
            m_axi_awprot  <= s_axi_awprot;
            m_axi_awvalid <= 1'b1;
            ptr           <= lane0;
            wcnt          <= '0;
            seen_last     <= 1'b0;
            m_axi_wstrb   <= '0;
`ifdef H265ENC_WR_ERR_CHK_EN
            awlen_q   <= s_axi_awlen;
            ncnt      <= '0;
            err_burst <= (s_axi_awsize != 3'd4) || (s_axi_awburst != 2'b01);
            if ((s_axi_awsize != 3'd4) || (s_axi_awburst != 2'b01))
              wr_err <= 1'b1;
`endif
            state <= ADDR;
          end
        end

        // Present the wide address to the host.
        ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            s_axi_wready  <= 1'b1;
            state         <= DATA;
          end
        end

        // Pack narrow beats into lanes; stall the encoder while a wide beat waits.
        DATA: begin
          if (s_axi_wvalid && s_axi_wready) begin
            for (int i = 0; i < RATIO; i++) begin
              if (ptr == LANE_W'(i)) begin
                m_axi_wdata[i*S_DWIDTH +: S_DWIDTH] <= s_axi_wdata;
                m_axi_wstrb[i*S_BYTES +: S_BYTES]   <= s_axi_wstrb;
              end
            end
            ptr <= ptr + LANE_W'(1);
            if (s_axi_wlast)
              seen_last <= 1'b1;
            if ((ptr == LANE_W'(RATIO - 1)) || s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              m_axi_wvalid <= 1'b1;
            end
`ifdef H265ENC_WR_ERR_CHK_EN
            ncnt <= ncnt + 8'd1;
            if (s_axi_wlast != (ncnt == awlen_q)) begin
              err_burst <= 1'b1;
              wr_err    <= 1'b1;
            end
`endif
          end
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
            m_axi_wstrb  <= '0;
            wcnt         <= wcnt + 8'd1;
            if (seen_last) begin
              m_axi_bready <= 1'b1;
              state        <= RESP;
            end else begin
              s_axi_wready <= 1'b1;
            end
          end
        end

        // Collect the host response, then hand it to the encoder.
        RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            s_axi_bvalid <= 1'b1;
`ifdef H265ENC_WR_ERR_CHK_EN
            s_axi_bresp  <= err_burst ? 2'b10 : m_axi_bresp;
`else
            s_axi_bresp  <= m_axi_bresp;
`endif
          end
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h265enc_axi_wr_upsizer.sv
`timescale 1ns/1ps
module tb_h265enc_axi_wr_upsizer;
  localparam int SW  = 128;
  localparam int MW  = 1024;
  localparam int R   = 8;
  localparam int SB  = 16;
  localparam int MB  = 128;
  localparam int TMO = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic [2:0]    s_axi_awsize;
  logic [1:0]    s_axi_awburst;
  logic [3:0]    s_axi_awcache;
  logic [2:0]    s_axi_awprot;
  logic          s_axi_awvalid;
  logic          s_axi_awready;
  logic [SW-1:0] s_axi_wdata;
  logic [SB-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_wvalid;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready;
  logic [63:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [MW-1:0] m_axi_wdata;
  logic [MB-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic          wr_err;

  always #5 clk = ~clk;

  h265enc_axi_wr_upsizer dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .wr_err(wr_err)
  );

  int checks = 0;
  int errors = 0;
  bit hung   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    hung = 1'b1;
    $display("FAIL %s no handshake within %0d cycles", name, TMO);
  endtask

  // Reference storage: narrow beats and the wide beats they should form.
  logic [SW-1:0] nd [0:255];
  logic [SB-1:0] ns [0:255];
  logic [MW-1:0] ed [0:63];
  logic [MB-1:0] es [0:63];
  logic [R-1:0]  el [0:63];

  task automatic chk_zero(input string tag);
    chk({tag, "_awready"}, s_axi_awready, 0);
    chk({tag, "_wready"},  s_axi_wready, 0);
    chk({tag, "_bvalid"},  s_axi_bvalid, 0);
    chk({tag, "_m_awvalid"}, m_axi_awvalid, 0);
    chk({tag, "_m_wvalid"},  m_axi_wvalid, 0);
    chk({tag, "_m_bready"},  m_axi_bready, 0);
    chk({tag, "_m_awaddr"},  m_axi_awaddr, 0);
    chk({tag, "_m_awlen"},   m_axi_awlen, 0);
    chk({tag, "_m_wstrb"},   m_axi_wstrb, 0);
    chk({tag, "_m_wdata_zero"}, m_axi_wdata == '0, 1);
    chk({tag, "_wr_err"},    wr_err, 0);
  endtask

  task automatic run_burst(input logic [63:0] addr, input int len, input logic [2:0] size,
                           input int stall, input logic [1:0] hresp, input int bdelay,
                           input bit rnd, input logic [63:0] x_awaddr, input logic [7:0] x_awlen);
    int lane0, nwide;
    logic x_err;
    logic [1:0] x_bresp;
    logic [3:0] cache;
    logic [2:0] prot;
    lane0 = int'(addr[6:4]);
    nwide = (lane0 + len) / R + 1;
    cache = 4'($urandom);
    prot  = 3'($urandom);
`ifdef H265ENC_WR_ERR_CHK_EN
    x_err = (size != 3'd4);
`else
    x_err = 1'b0;
`endif
    x_bresp = x_err ? 2'b10 : hresp;
    for (int w = 0; w < nwide; w++) begin
      ed[w] = '0; es[w] = '0; el[w] = '0;
    end
    for (int k = 0; k <= len; k++) begin
      int g;
      g = lane0 + k;
      nd[k] = {$urandom, $urandom, $urandom, $urandom};
      ns[k] = rnd ? SB'($urandom) : '1;
      ed[g/R][(g%R)*SW +: SW] = nd[k];
      es[g/R][(g%R)*SB +: SB] = ns[k];
      el[g/R][g%R] = 1'b1;
    end
    fork
      begin : s_side
        int n;
        s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size;
        s_axi_awburst = 2'b01; s_axi_awcache = cache; s_axi_awprot = prot;
        s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) tmo("s_aw_handshake");
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
          if (rnd) repeat ($urandom_range(0, 1)) @(negedge clk);
          s_axi_wdata = nd[k]; s_axi_wstrb = ns[k]; s_axi_wlast = (k == len);
          s_axi_wvalid = 1'b1;
          n = 0;
          while (!s_axi_wready && n < TMO) begin @(negedge clk); n++; end
          if (n >= TMO) begin tmo("s_w_handshake"); s_axi_wvalid = 1'b0; break; end
          @(negedge clk);
          s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        end
      end
      begin : m_side
        int n;
        logic [MW-1:0] hd;
        logic [MB-1:0] hs;
        n = 0;
        while (!m_axi_awvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) tmo("m_awvalid");
        else begin
          chk("m_awaddr", m_axi_awaddr, x_awaddr);
          chk("m_awlen", m_axi_awlen, x_awlen);
          chk("m_awsize", m_axi_awsize, 3'd7);
          chk("m_awburst", m_axi_awburst, 2'b01);
          chk("m_awcache", m_axi_awcache, cache);
          chk("m_awprot", m_axi_awprot, prot);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          m_axi_awready = 1'b1;
          @(negedge clk);
          m_axi_awready = 1'b0;
          chk("m_awvalid_drop", m_axi_awvalid, 0);
          for (int w = 0; w < nwide; w++) begin
            n = 0;
            while (!m_axi_wvalid && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) begin tmo("m_wvalid"); break; end
            hd = m_axi_wdata; hs = m_axi_wstrb;
            for (int s = 0; s < stall; s++) begin
              @(negedge clk);
              chk("stall_wvalid", m_axi_wvalid, 1);
              chk("stall_wstrb", m_axi_wstrb, hs);
              chk("stall_wdata_stable", m_axi_wdata == hd, 1);
              chk("stall_s_wready", s_axi_wready, 0);
            end
            m_axi_wready = 1'b1;
            for (int l = 0; l < R; l++)
              if (el[w][l]) chk($sformatf("wdata_b%0d_l%0d", w, l), m_axi_wdata[l*SW +: SW], ed[w][l*SW +: SW]);
            chk($sformatf("wstrb_b%0d", w), m_axi_wstrb, es[w]);
            chk($sformatf("wlast_b%0d", w), m_axi_wlast, (w == nwide - 1));
            @(negedge clk);
            m_axi_wready = 1'b0;
          end
          n = 0;
          while (!m_axi_bready && n < TMO) begin @(negedge clk); n++; end
          if (n >= TMO) tmo("m_bready");
          else begin
            m_axi_bresp = hresp; m_axi_bvalid = 1'b1;
            @(negedge clk);
            m_axi_bvalid = 1'b0;
          end
        end
      end
      begin : b_side
        int n;
        if (bdelay == 0) s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin tmo("s_bvalid"); s_axi_bready = 1'b0; end
        else begin
          repeat (bdelay) begin
            chk("bvalid_hold", s_axi_bvalid, 1);
            chk("bresp_hold", s_axi_bresp, x_bresp);
            @(negedge clk);
          end
          s_axi_bready = 1'b1;
          chk("bvalid", s_axi_bvalid, 1);
          chk("bresp", s_axi_bresp, x_bresp);
          @(negedge clk);
          s_axi_bready = 1'b0;
          chk("bvalid_clear", s_axi_bvalid, 0);
          chk("awready_back", s_axi_awready, 1);
          chk("wr_err", wr_err, x_err);
        end
      end
    join
  endtask

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          stall;
    logic [1:0]  hresp;
    int          bdelay;
    logic [63:0] x_awaddr;
    logic [7:0]  x_awlen;
  } vec_t;

  vec_t vt [7];

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd4; s_axi_awburst = 2'b01;
    s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;

    vt[0] = '{64'h1000, 7,   0, 2'b00, 0, 64'h1000, 8'd0};
    vt[1] = '{64'h1030, 9,   0, 2'b00, 0, 64'h1000, 8'd1};
    vt[2] = '{64'h1030, 9,   5, 2'b00, 1, 64'h1000, 8'd1};
    vt[3] = '{64'h1040, 0,   0, 2'b10, 3, 64'h1000, 8'd0};
    vt[4] = '{64'h10F0, 1,   1, 2'b01, 0, 64'h1080, 8'd1};
    vt[5] = '{64'h2000, 255, 0, 2'b00, 2, 64'h2000, 8'd31};
    vt[6] = '{64'h2070, 8,   2, 2'b11, 1, 64'h2000, 8'd1};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", s_axi_awready, 1);

    for (int i = 0; i < 7 && !hung; i++)
      run_burst(vt[i].addr, vt[i].len, 3'd4, vt[i].stall, vt[i].hresp, vt[i].bdelay, 1'b0,
                vt[i].x_awaddr, vt[i].x_awlen);

    for (int i = 0; i < 20 && !hung; i++) begin
      logic [63:0] base, a;
      int len, off;
      base = 64'h10000 + (64'($urandom_range(0, 15)) << 12);
      len  = $urandom_range(0, 31);
      off  = 16 * $urandom_range(0, 255 - len);
      a    = base + 64'(off);
      run_burst(a, len, 3'd4, $urandom_range(0, 3), 2'($urandom), $urandom_range(0, 2), 1'b1,
                a & ~64'h7F, 8'((((off / 16) % R) + len) / R));
    end

    // Reset in the middle of DATA after three narrow beats.
    if (!hung) begin
      int n;
      s_axi_awaddr = 64'h3000; s_axi_awlen = 8'd7; s_axi_awsize = 3'd4; s_axi_awvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) tmo("rst_aw");
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      n = 0;
      while (!m_axi_awvalid && n < TMO) begin @(negedge clk); n++; end
      if (n >= TMO) tmo("rst_m_aw");
      m_axi_awready = 1'b1;
      @(negedge clk);
      m_axi_awready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s_axi_wdata = {$urandom, $urandom, $urandom, $urandom}; s_axi_wstrb = '1;
        s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_wready && n < TMO) begin @(negedge clk); n++; end
        if (n >= TMO) begin tmo("rst_w"); break; end
        @(negedge clk);
        s_axi_wvalid = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_burst(64'h2000, 7, 3'd4, 0, 2'b00, 0, 1'b0, 64'h2000, 8'd0);
    end

    chk("wr_err_clean", wr_err, 0);
    if (!hung)
      run_burst(64'h4000, 7, 3'd3, 0, 2'b00, 1, 1'b0, 64'h4000, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/h265enc_axi_wr_upsizer.md
Name: h265enc_axi_wr_upsizer

Overview:
- Write-path AXI4 up-converter between the H.265 encoder core's 128-bit master port and the 1024-bit SNAP host write channels (AW/W/B).
- Packs narrow INCR write bursts into wide beats with correct lane strobes.
- Forwards the host write response back to the encoder.
- The read path is out of scope; it is handled by a separate block.

Parameters:
- S_DWIDTH, 128: encoder-side data width in bits.
- M_DWIDTH, 1024: host-side data width in bits.
- AWIDTH, 64: address width on both sides.
- RATIO, M_DWIDTH/S_DWIDTH (8): narrow beats per wide beat. Must be a power of two.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  AWIDTH  encoder write address.
- s_axi_awlen  in  8  narrow burst length minus 1.
- s_axi_awsize  in  3  encoder beat size; 4 is expected.
- s_axi_awburst  in  2  burst type; INCR is expected.
- s_axi_awcache  in  4  cache attribute, passed through.
- s_axi_awprot  in  3  protection attribute, passed through.
- s_axi_awvalid  in  1  address valid.
- s_axi_awready  out  1  address ready.
- s_axi_wdata  in  S_DWIDTH  narrow write data.
- s_axi_wstrb  in  S_DWIDTH/8  narrow byte strobes.
- s_axi_wlast  in  1  last narrow beat.
- s_axi_wvalid  in  1  data valid.
- s_axi_wready  out  1  data ready.
- s_axi_bresp  out  2  response to the encoder.
- s_axi_bvalid  out  1  response valid.
- s_axi_bready  in  1  response ready.
- m_axi_awaddr  out  AWIDTH  host address, aligned to M_DWIDTH/8.
- m_axi_awlen  out  8  wide burst length minus 1.
- m_axi_awsize  out  3  log2(M_DWIDTH/8) = 7.
- m_axi_awburst  out  2  fixed 2'b01 (INCR).
- m_axi_awcache  out  4  registered copy of s_axi_awcache.
- m_axi_awprot  out  3  registered copy of s_axi_awprot.
- m_axi_awvalid  out  1  host address valid.
- m_axi_awready  in  1  host address ready.
- m_axi_wdata  out  M_DWIDTH  packed wide data.
- m_axi_wstrb  out  M_DWIDTH/8  packed strobes.
- m_axi_wlast  out  1  last wide beat.
- m_axi_wvalid  out  1  wide data valid.
- m_axi_wready  in  1  wide data ready.
- m_axi_bresp  in  2  host response.
- m_axi_bvalid  in  1  host response valid.
- m_axi_bready  out  1  host response ready.
- wr_err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n low): FSM to IDLE; lane pointer, beat counter and buffer cleared.
  - All valid and ready outputs go to 0; m_axi_wdata, m_axi_wstrb, m_axi_awaddr, m_axi_awlen and wr_err go to 0.
  - Reset asserted mid-burst abandons the burst with no response generated.
- One burst in flight at a time. FSM states are IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - s_axi_awready = 1.
  - On the AW handshake, latch the following values:
    - lane0 = awaddr[log2(M_DWIDTH/8)-1:4].
    - m_axi_awaddr = awaddr with its low 7 bits cleared.
    - m_axi_awlen = (lane0 + s_axi_awlen) >> log2(RATIO), computed 9 bits wide and truncated to 8.
    - cache and prot.
  - Go to ADDR.
- ADDR:
  - m_axi_awvalid = 1 until m_axi_awready is seen, then go to DATA. Registered: awvalid rises 1 cycle after the s-side AW handshake.
  - s_axi_wready = 0.
- DATA, packing:
  - The lane pointer starts at lane0.
  - Each accepted narrow beat writes its data and strobes into buffer lane[ptr], then ptr increments.
  - Lanes below lane0 in the first wide beat, and lanes after wlast in the final wide beat, carry strobe 0.
  - A wide beat is complete when ptr wraps from RATIO-1 to 0 or when s_axi_wlast is accepted.
  - On completion, m_axi_wvalid = 1 from the next cycle. Data and strobes are held stable until m_axi_wready.
  - s_axi_wready = 0 while a wide beat is pending.
  - On the wide handshake: strobes cleared, wide beat counter increments, s_axi_wready re-asserts the next cycle. No zero-bubble overlap is required.
  - m_axi_wlast = 1 when wide count == m_axi_awlen.
  - After the wide handshake with wlast, go to RESP.
- RESP:
  - m_axi_bready = 1 until m_axi_bvalid is seen; bresp is latched.
  - s_axi_bvalid = 1 with the latched bresp until s_axi_bready, then go to IDLE.
  - Simultaneous s_axi_bready and s_axi_bvalid-set: s_axi_bvalid is held for at least one cycle.
- Constraints the encoder guarantees: no burst crosses a 4 KB boundary; awaddr is 16-byte aligned.

Optional Feature:
- Macro: H265ENC_WR_ERR_CHK_EN.
- Defined:
  - The AW handshake flags an error if awsize != 3'd4 or awburst != 2'b01.
  - A W handshake flags an error if s_axi_wlast disagrees with the narrow beat count versus s_axi_awlen.
  - Any error sets wr_err, which stays set until reset.
  - The burst's s_axi_bresp is forced to 2'b10 (SLVERR), regardless of the host response.
  - The burst still completes; if wlast is early, packing terminates on s_axi_wlast.
- Not defined: no checks; wr_err is tied to 0; bresp passes through unchanged.

Test Plan:
- awaddr=0x1000, awlen=7, 8 beats of 16 B -> m_axi_awaddr=0x1000, awlen=0, one wide beat with wstrb all ones, wlast=1, s_axi_bresp=OKAY.
- awaddr=0x1030, awlen=9 -> lane0=3, m_axi_awlen=1; beat0 wstrb=0xFFFF..._FFFF_FFFF_0000_0000_0000 (lanes 0-2 zero); beat1 lanes 0-4 set, lanes 5-7 zero, wlast=1.
- Same burst as above with m_axi_wready held low for 5 cycles -> wvalid, wdata and wstrb stable, s_axi_wready=0 throughout, no data lost.
- m_axi_bresp=2'b10 with s_axi_bready low for 3 cycles -> s_axi_bvalid held with SLVERR, then IDLE and awready=1 on the cycle after the handshake.
- rst_n pulsed low during DATA after 3 narrow beats -> all outputs 0 immediately; a new burst awaddr=0x2000, awlen=7 then completes correctly.
- With H265ENC_WR_ERR_CHK_EN: awsize=3'd3 -> wr_err=1, s_axi_bresp=2'b10; without the macro, wr_err stays 0.
